// File: rtl/pa_mem_if_if.sv
// pa_mem_if_if: handshake and SRAM bus bundle between the accelerator,
// the pa_mem_if bridge and the shared single-port SRAM.
//   Read handshake : data, read_rdy (bridge -> accel), read_acq (accel -> bridge)
//   Write handshake: result_out, write_rdy (accel -> bridge), write_acq (bridge -> accel)
//   SRAM bus       : mem_addr, mem_rd_en, mem_wr_en, mem_wdata (bridge -> SRAM),
//                    mem_rdata (SRAM -> bridge, one cycle after mem_rd_en)
// The slave modport is the bridge's view; master is the environment's view.
interface pa_mem_if_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [DW-1:0] data;
    logic          read_rdy;
    logic          read_acq;
    logic [DW-1:0] result_out;
    logic          write_rdy;
    logic          write_acq;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        output data, read_rdy, write_acq, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  read_acq, result_out, write_rdy, mem_rdata
    );

    modport master (
        input  data, read_rdy, write_acq, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output read_acq, result_out, write_rdy, mem_rdata
    );
endinterface

// File: rtl/pa_mem_if.sv
// pa_mem_if: memory-side bridge for the PE-array accelerator.
// Prefetches words from a single-port synchronous SRAM into a small FIFO
// and presents them on the read handshake; accepts results on the write
// handshake and stores them to the destination region. Writes win over reads.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse clearing counters, FIFO and phase register
//   state          accelerator phase (00 idle, 01 weights, 10 data, 11 compute)
//   mem_bias_addr  word offset added to the phase base on phase entry
//   weight_base    base of the weight region
//   lhs_base       base of the input-data region
//   dst_base       base of the result region
//   wr_count       results written since start (saturating)
//   bus            handshake + SRAM bus (slave view)
module pa_mem_if #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int PF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    state,
    input  logic [31:0]   mem_bias_addr,
    input  logic [AW-1:0] weight_base,
    input  logic [AW-1:0] lhs_base,
    input  logic [AW-1:0] dst_base,
    output logic [15:0]   wr_count,
    pa_mem_if_if.slave    bus
);
    localparam int PW = (PF_DEPTH > 2) ? $clog2(PF_DEPTH) : 1;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'b00,
        PH_WEIGHT  = 2'b01,
        PH_STREAM  = 2'b10,
        PH_COMPUTE = 2'b11
    } phase_t;

    phase_t        r_state_q;
    logic          r_drop;
    logic          r_inflight;
    logic [AW-1:0] r_rd_addr;
    logic [15:0]   r_wr_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [DW-1:0] r_fifo [PF_DEPTH];

    phase_t        w_phase;
    logic          w_phase_entry;
    logic          w_flush;
    logic          w_wr_grant;
    logic          w_pop;
    logic          w_push;
    logic          w_rd_phase;
    logic          w_room;
    logic          w_rd_en;
    logic [PW+1:0] w_occupancy;
    logic [AW-1:0] w_wr_addr;

    assign w_phase       = phase_t'(state);
    // start takes precedence; the phase change is seen again once state_q is 00
    assign w_phase_entry = (w_phase != r_state_q) && !start;
    assign w_flush       = start || w_phase_entry;
    // rst_n keeps the combinational write outputs at 0 while in reset
    assign w_wr_grant    = bus.write_rdy && rst_n;
    assign w_pop         = (r_count != '0) && bus.read_acq;
    // a return landing in a flush cycle belongs to the old phase
    assign w_push        = r_inflight && !r_drop && !w_flush;
    assign w_rd_phase    = (w_phase == PH_WEIGHT) || (w_phase == PH_STREAM);

    // slots committed (buffered + returning) minus the one leaving this cycle
    assign w_occupancy   = (PW+2)'(r_count) + (PW+2)'(r_inflight) - (PW+2)'(w_pop);
    assign w_room        = w_occupancy < (PW+2)'(PF_DEPTH);
    assign w_rd_en       = w_rd_phase && !w_flush && w_room && !w_wr_grant;

    // a write in the start cycle lands at offset 0, since the count is being cleared
    assign w_wr_addr     = dst_base + AW'(start ? 16'd0 : r_wr_count);

    assign bus.write_acq = w_wr_grant;
    assign bus.mem_wr_en = w_wr_grant;
    assign bus.mem_rd_en = w_rd_en;
    assign bus.mem_addr  = w_wr_grant ? w_wr_addr : (w_rd_en ? r_rd_addr : '0);
    assign bus.mem_wdata = w_wr_grant ? bus.result_out : '0;
    assign bus.read_rdy  = (r_count != '0);
    assign bus.data      = (r_count != '0) ? r_fifo[r_rd_ptr] : '0;
    assign wr_count      = r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= PH_IDLE;
            r_drop     <= 1'b0;
            r_inflight <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_count <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_drop     <= w_flush;
            r_inflight <= w_rd_en;

            if (start) begin
                r_state_q <= PH_IDLE;
                r_rd_addr <= '0;
            end else if (w_phase_entry) begin
                r_state_q <= w_phase;
                if (w_phase == PH_WEIGHT)
                    r_rd_addr <= weight_base + AW'(mem_bias_addr);
                else if (w_phase == PH_STREAM)
                    r_rd_addr <= lhs_base + AW'(mem_bias_addr);
            end else if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end

            if (w_wr_grant) begin
                if (start)
                    r_wr_count <= 16'd1;
                else if (r_wr_count != 16'hFFFF)
                    r_wr_count <= r_wr_count + 16'd1;
            end else if (start) begin
                r_wr_count <= '0;
            end

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            end
        end
    end

    // FIFO storage needs no reset: data is masked to 0 whenever the FIFO is empty
    generate
        for (genvar gi = 0; gi < PF_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PW'(gi)))
                    r_fifo[gi] <= bus.mem_rdata;
            end
        end
    endgenerate
endmodule

// File: tb/tb_pa_mem_if.sv
module tb_pa_mem_if;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  state = 2'b00;
    logic [31:0] mem_bias_addr = '0;
    logic [31:0] weight_base = '0;
    logic [31:0] lhs_base = '0;
    logic [31:0] dst_base = '0;
    logic [15:0] wr_count;
    int          n_vec = 0;
    int          n_miss = 0;

    pa_mem_if_if #(.AW(32), .DW(32)) bus ();

    pa_mem_if #(.AW(32), .DW(32), .PF_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .state         (state),
        .mem_bias_addr (mem_bias_addr),
        .weight_base   (weight_base),
        .lhs_base      (lhs_base),
        .dst_base      (dst_base),
        .wr_count      (wr_count),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // SRAM contents are a fixed function of the address
    function automatic logic [31:0] f(input logic [31:0] a);
        return 32'hD000_0000 ^ a;
    endfunction

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rdata <= f(bus.mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rdy"},   64'(bus.read_rdy),  64'd0);
        chk({tag, "_data"},  64'(bus.data),      64'd0);
        chk({tag, "_rden"},  64'(bus.mem_rd_en), 64'd0);
        chk({tag, "_wren"},  64'(bus.mem_wr_en), 64'd0);
        chk({tag, "_wacq"},  64'(bus.write_acq), 64'd0);
        chk({tag, "_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, "_wrcnt"}, 64'(wr_count),      64'd0);
    endtask

    initial begin
        bus.read_acq   = 1'b0;
        bus.write_rdy  = 1'b0;
        bus.result_out = '0;
        bus.mem_rdata  = '0;

        // reset values
        repeat (3) tick();
        #1 chk_idle_outputs("reset");
        tick();
        rst_n = 1'b1;

        // streaming weights with read_acq held high; 64 words in order
        tick();
        start = 1'b1; state = 2'b01; weight_base = 32'h100; mem_bias_addr = 32'd4;
        bus.read_acq = 1'b1;
        #1 chk("t1_start_nord", 64'(bus.mem_rd_en), 64'd0);
        tick();
        start = 1'b0;
        #1 chk("t1_entry_nord", 64'(bus.mem_rd_en), 64'd0);
        for (int k = 1; k <= 66; k++) begin
            tick();
            #1;
            chk($sformatf("t1_rden_%0d", k), 64'(bus.mem_rd_en), 64'd1);
            chk($sformatf("t1_addr_%0d", k), 64'(bus.mem_addr), 64'(32'h104 + k - 1));
            if (k < 3) begin
                chk($sformatf("t1_rdy_%0d", k), 64'(bus.read_rdy), 64'd0);
            end else begin
                chk($sformatf("t1_rdy_%0d", k), 64'(bus.read_rdy), 64'd1);
                chk($sformatf("t1_data_%0d", k), 64'(bus.data), 64'(f(32'h104 + k - 3)));
            end
        end

        // read_acq low: prefetch stops after two reads, head held stable
        tick();
        start = 1'b1; bus.read_acq = 1'b0;
        tick();
        start = 1'b0;
        tick();
        #1 chk("t2_c1_rden", 64'(bus.mem_rd_en), 64'd1);
        chk("t2_c1_addr", 64'(bus.mem_addr), 64'h104);
        tick();
        #1 chk("t2_c2_addr", 64'(bus.mem_addr), 64'h105);
        tick();
        #1 chk("t2_c3_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t2_c3_rdy", 64'(bus.read_rdy), 64'd1);
        chk("t2_c3_data", 64'(bus.data), 64'(f(32'h104)));
        tick();
        #1 chk("t2_c4_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t2_c4_data", 64'(bus.data), 64'(f(32'h104)));
        tick();
        bus.read_acq = 1'b1;
        #1 chk("t2_pulse_rden", 64'(bus.mem_rd_en), 64'd1);
        chk("t2_pulse_addr", 64'(bus.mem_addr), 64'h106);
        chk("t2_pulse_data", 64'(bus.data), 64'(f(32'h104)));
        tick();
        bus.read_acq = 1'b0;
        #1 chk("t2_c6_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t2_c6_data", 64'(bus.data), 64'(f(32'h105)));
        tick();
        #1 chk("t2_c7_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t2_c7_data", 64'(bus.data), 64'(f(32'h105)));

        // phase change 01 -> 10 with a word buffered and one in flight
        tick();
        bus.read_acq = 1'b1;
        #1 chk("t3_c8_addr", 64'(bus.mem_addr), 64'h107);
        chk("t3_c8_data", 64'(bus.data), 64'(f(32'h105)));
        tick();
        bus.read_acq = 1'b0; state = 2'b10; lhs_base = 32'h200; mem_bias_addr = 32'd0;
        #1 chk("t3_entry_nord", 64'(bus.mem_rd_en), 64'd0);
        tick();
        #1 chk("t3_c10_rdy", 64'(bus.read_rdy), 64'd0);
        chk("t3_c10_addr", 64'(bus.mem_addr), 64'h200);
        tick();
        #1 chk("t3_c11_rdy", 64'(bus.read_rdy), 64'd0);
        chk("t3_c11_addr", 64'(bus.mem_addr), 64'h201);
        tick();
        bus.read_acq = 1'b1; dst_base = 32'h300;
        #1 chk("t3_c12_rdy", 64'(bus.read_rdy), 64'd1);
        chk("t3_c12_data", 64'(bus.data), 64'(f(32'h200)));
        chk("t3_c12_addr", 64'(bus.mem_addr), 64'h202);

        // three writes interleaved with streaming
        tick();
        #1 chk("t4_c13_data", 64'(bus.data), 64'(f(32'h201)));
        chk("t4_c13_addr", 64'(bus.mem_addr), 64'h203);
        tick();
        bus.write_rdy = 1'b1; bus.result_out = 32'h1122_3344;
        #1 chk("t4_w0_acq", 64'(bus.write_acq), 64'd1);
        chk("t4_w0_wren", 64'(bus.mem_wr_en), 64'd1);
        chk("t4_w0_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t4_w0_addr", 64'(bus.mem_addr), 64'h300);
        chk("t4_w0_wdata", 64'(bus.mem_wdata), 64'h1122_3344);
        chk("t4_w0_data", 64'(bus.data), 64'(f(32'h202)));
        tick();
        bus.result_out = 32'h5566_7788;
        #1 chk("t4_w1_acq", 64'(bus.write_acq), 64'd1);
        chk("t4_w1_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t4_w1_addr", 64'(bus.mem_addr), 64'h301);
        chk("t4_w1_wdata", 64'(bus.mem_wdata), 64'h5566_7788);
        chk("t4_w1_wrcnt", 64'(wr_count), 64'd1);
        chk("t4_w1_data", 64'(bus.data), 64'(f(32'h203)));
        tick();
        bus.result_out = 32'h99AA_BBCC;
        #1 chk("t4_w2_acq", 64'(bus.write_acq), 64'd1);
        chk("t4_w2_rden", 64'(bus.mem_rd_en), 64'd0);
        chk("t4_w2_addr", 64'(bus.mem_addr), 64'h302);
        chk("t4_w2_wdata", 64'(bus.mem_wdata), 64'h99AA_BBCC);
        chk("t4_w2_rdy", 64'(bus.read_rdy), 64'd0);
        tick();
        bus.write_rdy = 1'b0;
        #1 chk("t4_c17_acq", 64'(bus.write_acq), 64'd0);
        chk("t4_c17_wren", 64'(bus.mem_wr_en), 64'd0);
        chk("t4_c17_rden", 64'(bus.mem_rd_en), 64'd1);
        chk("t4_c17_addr", 64'(bus.mem_addr), 64'h204);
        chk("t4_c17_wrcnt", 64'(wr_count), 64'd3);
        tick();
        #1 chk("t4_c18_addr", 64'(bus.mem_addr), 64'h205);
        chk("t4_c18_rdy", 64'(bus.read_rdy), 64'd0);
        tick();
        #1 chk("t4_c19_data", 64'(bus.data), 64'(f(32'h204)));
        chk("t4_c19_addr", 64'(bus.mem_addr), 64'h206);
        tick();
        #1 chk("t4_c20_data", 64'(bus.data), 64'(f(32'h205)));

        // write coinciding with start goes to dst_base + 0
        tick();
        start = 1'b1; bus.write_rdy = 1'b1; bus.result_out = 32'hCAFE_0001; bus.read_acq = 1'b0;
        #1 chk("t5_acq", 64'(bus.write_acq), 64'd1);
        chk("t5_addr", 64'(bus.mem_addr), 64'h300);
        chk("t5_wdata", 64'(bus.mem_wdata), 64'hCAFE_0001);
        chk("t5_rden", 64'(bus.mem_rd_en), 64'd0);
        tick();
        start = 1'b0; bus.write_rdy = 1'b0;
        #1 chk("t5_wrcnt", 64'(wr_count), 64'd1);

        // wr_count saturation at 0xFFFF
        tick();
        bus.write_rdy = 1'b1; bus.result_out = 32'hCAFE_0002;
        #1 chk("t6_first_addr", 64'(bus.mem_addr), 64'h301);
        repeat (65534) tick();
        #1 chk("t6_sat_wrcnt", 64'(wr_count), 64'hFFFF);
        chk("t6_sat_addr", 64'(bus.mem_addr), 64'h102FF);
        chk("t6_sat_rden", 64'(bus.mem_rd_en), 64'd0);
        tick();
        #1 chk("t6_hold_wrcnt", 64'(wr_count), 64'hFFFF);
        chk("t6_hold_addr", 64'(bus.mem_addr), 64'h102FF);

        // asynchronous reset with a read in flight
        tick();
        bus.write_rdy = 1'b0; start = 1'b1; state = 2'b01;
        weight_base = 32'h100; mem_bias_addr = 32'd4; bus.read_acq = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1 chk("t7_pre_addr", 64'(bus.mem_addr), 64'h105);
        rst_n = 1'b0;
        #1 chk_idle_outputs("t7_rst");
        tick();
        rst_n = 1'b1; weight_base = 32'h400; mem_bias_addr = 32'd0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1 chk("t7_c1_rdy", 64'(bus.read_rdy), 64'd0);
        chk("t7_c1_addr", 64'(bus.mem_addr), 64'h400);
        tick();
        #1 chk("t7_c2_rdy", 64'(bus.read_rdy), 64'd0);
        chk("t7_c2_addr", 64'(bus.mem_addr), 64'h401);
        tick();
        #1 chk("t7_c3_rdy", 64'(bus.read_rdy), 64'd1);
        chk("t7_c3_data", 64'(bus.data), 64'(f(32'h400)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
